// File: rtl/regfile_access_ctrl.sv
// Front-end for a 1W/1R register file: post-reset clear sweep, then round-robin
// arbitration of NUM_REQ requesters with in-order, fixed 1-cycle responses.
module regfile_access_ctrl #(
  parameter int                    NUM_REQ       = 2,
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          init_done,
  output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
  output logic [DATA_WIDTH-1:0]         rf_wr_data,
  output logic                          rf_wr_en,
  output logic [ADDR_WIDTH-1:0]         rf_rd_addr,
  output logic                          rf_rd_en,
  input  logic [DATA_WIDTH-1:0]         rf_rd_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [PTR_W-1:0]      rr_ptr;
  logic                  rsp_is_read;

  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      cand;
  logic                  sel_write;

  // Round-robin scan starting at rr_ptr; arbitration is blocked in INIT and reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (rst || state != ST_RUN) begin
      grant_any = 1'b0;
    end
  end

  assign sel_write = req_write[grant_idx];
  assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_next = state;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    if (state == ST_INIT) begin
      if (init_cnt == ADDR_WIDTH'(2**ADDR_WIDTH - 1)) begin
        state_next = ST_RUN;
      end
      if (!rst) begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = init_cnt;
        rf_wr_data = INIT_VALUE;
      end
    end else if (grant_any) begin
      if (sel_write) begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        rf_wr_data = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      init_cnt    <= '0;
      rr_ptr      <= '0;
      rsp_valid   <= '0;
      rsp_is_read <= 1'b0;
    end else begin
      state       <= state_next;
      rsp_valid   <= req_ready;
      rsp_is_read <= grant_any & ~sel_write;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if (grant_any) begin
        rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // The sweep hands over to RUN only after its last write, so RUN implies init done.
  assign init_done = (state == ST_RUN);
  assign rsp_rdata = rsp_is_read ? rf_rd_data : '0;

endmodule
